// File: rtl/vliw_fetch.sv
// vliw_fetch: fetch stage for a 4-slot VLIW core.
// Each cycle it requests one 128-bit bundle at pc. An accepted bundle lands in the
// instruction register (IR) on the next edge. The stage also handles stall, branch
// redirect with a one-cycle squash, and halting on a HALT_INST encoding in slot 0.
module vliw_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_valid,
    input  logic [127:0] imem_data,
    output logic [31:0]  inst_slot0,
    output logic [31:0]  inst_slot1,
    output logic [31:0]  inst_slot2,
    output logic [31:0]  inst_slot3,
    output logic         bundle_valid,
    output logic         branch_squash,
    output logic [31:0]  pc_out,
    output logic [31:0]  bundle_count,
    output logic [1:0]   dbg_state
);

    // Handshake: imem_req is driven combinationally from the current state and this
    // cycle's stall/branch. A response counts only in a cycle where imem_req and
    // imem_valid are both high. No request is kept pending across cycles: a cycle
    // without acceptance simply re-requests the same address on the next cycle.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Bundles are 16-byte aligned, so the low nibble of any fetch address is zero.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:4], 4'b0000};

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic [127:0]  ir_q, ir_d;
    logic          bv_q, bv_d;
    logic          squash_q, squash_d;
    logic [31:0]   count_q, count_d;
    logic          accept;
    logic          redirect;

    // A redirect is honoured everywhere except HALT, and it outranks stall and acceptance.
    always_comb begin
        redirect = branch_taken && (state_q != ST_HALT);
        imem_req = 1'b0;
        if (!rst && (state_q == ST_RUN)) begin
            imem_req = !stall && !branch_taken;
        end
        accept = imem_req && imem_valid;
    end

    // Next-state and datapath update: branch, then stall, then acceptance, then idle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        ir_d     = ir_q;
        bv_d     = bv_q;
        count_d  = count_q;
        squash_d = redirect;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (branch_taken) begin
                    pc_d = {branch_target[31:4], 4'b0000};
                    ir_d = '0;
                    bv_d = 1'b0;
                end else if (!stall) begin
                    ir_d = '0;
                    bv_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d = {branch_target[31:4], 4'b0000};
                    ir_d = '0;
                    bv_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; imem_req is low so nothing can be accepted.
                end else if (accept) begin
                    ir_d     = imem_data;
                    bv_d     = 1'b1;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 32'd16;
                    count_d  = count_q + 32'd1;
                    if (imem_data[31:0] == HALT_INST) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    ir_d = '0;
                    bv_d = 1'b0;
                end
            end
            ST_HALT: begin
                // The halting bundle stays visible until the first non-stall cycle.
                if (!stall) begin
                    ir_d = '0;
                    bv_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous reset; reset overrides stall and branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC_ALIGNED;
            pc_out_q <= RESET_PC_ALIGNED;
            ir_q     <= '0;
            bv_q     <= 1'b0;
            squash_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            ir_q     <= ir_d;
            bv_q     <= bv_d;
            squash_q <= squash_d;
            count_q  <= count_d;
        end
    end

    // Output mapping: slot n of the IR is bits [32n+31:32n].
    always_comb begin
        imem_addr     = pc_q;
        inst_slot0    = ir_q[31:0];
        inst_slot1    = ir_q[63:32];
        inst_slot2    = ir_q[95:64];
        inst_slot3    = ir_q[127:96];
        bundle_valid  = bv_q;
        branch_squash = squash_q;
        pc_out        = pc_out_q;
        bundle_count  = count_q;
        dbg_state     = state_q;
    end

endmodule
